// File: rtl/decode_hazard_if.sv
// -----------------------------------------------------------------------------
// decode_hazard_if
// Groups the decode-stage hazard controller's bus signals.
//   Decode side   : dec_v_i, dec_rs1_v_i/dec_rs1_i, dec_rs2_v_i/dec_rs2_i,
//                   dec_ld_v_i, dec_rd_i, dec_br_v_i
//   Memory side   : ld_done_v_i, ld_done_rd_i
//   Execute side  : br_res_v_i, br_taken_i
//   Controls out  : issue_v_o, decode_stall_v_o, decode_flush_v_o,
//                   fetch_stall_v_o, err_o
// The _i/_o suffixes are named from the controller's point of view:
// the master modport is the pipeline around the controller and the
// slave modport is the controller itself.
// -----------------------------------------------------------------------------
interface decode_hazard_if #(
   parameter int reg_addr_width_p = 5
) ();
   logic                        dec_v_i;
   logic                        dec_rs1_v_i;
   logic [reg_addr_width_p-1:0] dec_rs1_i;
   logic                        dec_rs2_v_i;
   logic [reg_addr_width_p-1:0] dec_rs2_i;
   logic                        dec_ld_v_i;
   logic [reg_addr_width_p-1:0] dec_rd_i;
   logic                        dec_br_v_i;
   logic                        ld_done_v_i;
   logic [reg_addr_width_p-1:0] ld_done_rd_i;
   logic                        br_res_v_i;
   logic                        br_taken_i;
   logic                        issue_v_o;
   logic                        decode_stall_v_o;
   logic                        decode_flush_v_o;
   logic                        fetch_stall_v_o;
   logic                        err_o;

   modport master (
      output dec_v_i, dec_rs1_v_i, dec_rs1_i, dec_rs2_v_i, dec_rs2_i,
             dec_ld_v_i, dec_rd_i, dec_br_v_i, ld_done_v_i, ld_done_rd_i,
             br_res_v_i, br_taken_i,
      input  issue_v_o, decode_stall_v_o, decode_flush_v_o, fetch_stall_v_o, err_o
   );

   modport slave (
      input  dec_v_i, dec_rs1_v_i, dec_rs1_i, dec_rs2_v_i, dec_rs2_i,
             dec_ld_v_i, dec_rd_i, dec_br_v_i, ld_done_v_i, ld_done_rd_i,
             br_res_v_i, br_taken_i,
      output issue_v_o, decode_stall_v_o, decode_flush_v_o, fetch_stall_v_o, err_o
   );
endinterface

// File: rtl/decode_hazard_ctl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctl
// Decode-stage sequencing controller. Tracks in-flight loads with a per-register
// scoreboard and a load counter, and runs a small branch FSM:
//   IDLE    : stall decode+fetch on load-use hazard or load-count overflow
//   BR_WAIT : freeze decode+fetch until execute resolves the branch
//   FLUSH   : bubble decode for flush_cycles_p cycles after a taken branch
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   hz_if  - decode_hazard_if.slave (decode/load/branch inputs, control outputs)
// Control outputs are combinational from state and inputs and forced low while
// rst_i is asserted. err_o is a sticky flag for protocol violations
// (load completion with nothing in flight, branch resolve outside BR_WAIT).
// The interface's reg_addr_width_p must match this module's.
// -----------------------------------------------------------------------------
module decode_hazard_ctl #(
   parameter int reg_addr_width_p = 5,
   parameter int max_ld_p         = 2,
   parameter int flush_cycles_p   = 2
) (
   input logic            clk_i,
   input logic            rst_i,
   decode_hazard_if.slave hz_if
);

   localparam int num_regs_lp = 2 ** reg_addr_width_p;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BR_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_e;

   state_e                      state_r;
   state_e                      state_next_s;
   logic [num_regs_lp-1:0]      sb_r;
   logic [num_regs_lp-1:0]      sb_next_s;
   logic [2:0]                  ld_cnt_r;
   logic [2:0]                  ld_cnt_next_s;
   logic [2:0]                  flush_cnt_r;
   logic [2:0]                  flush_cnt_next_s;
   logic                        err_r;
   logic                        err_next_s;

   logic                        hazard_s;
   logic                        ld_full_s;
   logic                        issue_s;
   logic                        stall_s;
   logic                        flush_s;
   logic                        fetch_stall_s;
   logic                        br_err_s;
   logic                        ld_err_s;
   logic                        ld_issue_s;

   // Hazard detect: x0 never reads as busy because its scoreboard bit is never set.
   always_comb begin
      hazard_s  = hz_if.dec_v_i &
                  ((hz_if.dec_rs1_v_i & sb_r[hz_if.dec_rs1_i]) |
                   (hz_if.dec_rs2_v_i & sb_r[hz_if.dec_rs2_i]));
      ld_full_s = hz_if.dec_v_i & hz_if.dec_ld_v_i & (ld_cnt_r == 3'(max_ld_p));
   end

   // Branch FSM next state and per-state controls.
   always_comb begin
      state_next_s     = state_r;
      flush_cnt_next_s = flush_cnt_r;
      stall_s          = 1'b0;
      flush_s          = 1'b0;
      fetch_stall_s    = 1'b0;
      issue_s          = 1'b0;
      br_err_s         = 1'b0;
      case (state_r)
         IDLE: begin
            stall_s       = hazard_s | ld_full_s;
            fetch_stall_s = stall_s;
            issue_s       = hz_if.dec_v_i & ~stall_s;
            br_err_s      = hz_if.br_res_v_i;
            if (issue_s && hz_if.dec_br_v_i) begin
               state_next_s = BR_WAIT;
            end else begin
               state_next_s = IDLE;
            end
         end
         BR_WAIT: begin
            stall_s       = 1'b1;
            fetch_stall_s = 1'b1;
            if (hz_if.br_res_v_i && hz_if.br_taken_i) begin
               state_next_s     = FLUSH;
               flush_cnt_next_s = 3'(flush_cycles_p);
            end else if (hz_if.br_res_v_i) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = BR_WAIT;
            end
         end
         FLUSH: begin
            flush_s          = 1'b1;
            br_err_s         = hz_if.br_res_v_i;
            flush_cnt_next_s = flush_cnt_r - 3'd1;
            // Count was loaded with the flush length, so the cycle seeing 1 is the last.
            if (flush_cnt_r == 3'd1) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = FLUSH;
            end
         end
         default: begin
            state_next_s     = IDLE;
            flush_cnt_next_s = 3'd0;
         end
      endcase
   end

   // Scoreboard and load counter next values; a set on the same index beats a clear.
   always_comb begin
      ld_issue_s    = issue_s & hz_if.dec_ld_v_i;
      ld_err_s      = hz_if.ld_done_v_i & (ld_cnt_r == 3'd0);
      sb_next_s     = sb_r;
      ld_cnt_next_s = ld_cnt_r;
      if (hz_if.ld_done_v_i) begin
         sb_next_s[hz_if.ld_done_rd_i] = 1'b0;
      end else begin
         sb_next_s = sb_r;
      end
      if (ld_issue_s && (hz_if.dec_rd_i != {reg_addr_width_p{1'b0}})) begin
         sb_next_s[hz_if.dec_rd_i] = 1'b1;
      end else begin
         sb_next_s = sb_next_s;
      end
      case ({ld_issue_s, hz_if.ld_done_v_i})
         2'b10:   ld_cnt_next_s = ld_cnt_r + 3'd1;
         // A completion with nothing in flight leaves the count at zero.
         2'b01:   ld_cnt_next_s = ld_err_s ? ld_cnt_r : (ld_cnt_r - 3'd1);
         default: ld_cnt_next_s = ld_cnt_r;
      endcase
      err_next_s = err_r | ld_err_s | br_err_s;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= IDLE;
         sb_r        <= {num_regs_lp{1'b0}};
         ld_cnt_r    <= 3'd0;
         flush_cnt_r <= 3'd0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         sb_r        <= sb_next_s;
         ld_cnt_r    <= ld_cnt_next_s;
         flush_cnt_r <= flush_cnt_next_s;
         err_r       <= err_next_s;
      end
   end

   assign hz_if.issue_v_o        = issue_s & ~rst_i;
   assign hz_if.decode_stall_v_o = stall_s & ~rst_i;
   assign hz_if.decode_flush_v_o = flush_s & ~rst_i;
   assign hz_if.fetch_stall_v_o  = fetch_stall_s & ~rst_i;
   assign hz_if.err_o            = err_r & ~rst_i;

endmodule

// File: tb/tb_decode_hazard_ctl.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_ctl
// Directed scenarios followed by random traffic, checked every cycle against a
// behavioural model: a busy-register bit set, an in-flight load count, a
// "branch outstanding" flag and a remaining-flush-cycles count.
// -----------------------------------------------------------------------------
module tb_decode_hazard_ctl;

   localparam int ra_lp    = 5;
   localparam int max_ld_lp = 2;
   localparam int flush_lp  = 2;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   // behavioural model state
   bit [31:0] busy_m;
   int        inflight_m;
   bit        br_out_m;
   int        flush_left_m;
   bit        err_m;

   decode_hazard_if #(.reg_addr_width_p(ra_lp)) hz_if ();

   decode_hazard_ctl #(
      .reg_addr_width_p(ra_lp),
      .max_ld_p        (max_ld_lp),
      .flush_cycles_p  (flush_lp)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz_if (hz_if.slave)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic got, input logic exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   task automatic clear_in();
      rst                  = 1'b0;
      hz_if.dec_v_i        = 1'b0;
      hz_if.dec_rs1_v_i    = 1'b0;
      hz_if.dec_rs1_i      = 5'd0;
      hz_if.dec_rs2_v_i    = 1'b0;
      hz_if.dec_rs2_i      = 5'd0;
      hz_if.dec_ld_v_i     = 1'b0;
      hz_if.dec_rd_i       = 5'd0;
      hz_if.dec_br_v_i     = 1'b0;
      hz_if.ld_done_v_i    = 1'b0;
      hz_if.ld_done_rd_i   = 5'd0;
      hz_if.br_res_v_i     = 1'b0;
      hz_if.br_taken_i     = 1'b0;
   endtask

   // One cycle: check outputs against the model for the applied inputs, then advance model.
   task automatic step();
      bit e_issue, e_stall, e_flush, e_fetch, e_err, busy_read, too_many;
      #2;
      e_issue = 0; e_stall = 0; e_flush = 0; e_fetch = 0; e_err = 0;
      if (!rst) begin
         e_err = err_m;
         if (flush_left_m > 0) begin
            e_flush = 1;
         end else if (br_out_m) begin
            e_stall = 1;
            e_fetch = 1;
         end else begin
            busy_read = hz_if.dec_v_i &&
                        ((hz_if.dec_rs1_v_i && busy_m[hz_if.dec_rs1_i]) ||
                         (hz_if.dec_rs2_v_i && busy_m[hz_if.dec_rs2_i]));
            too_many  = hz_if.dec_v_i && hz_if.dec_ld_v_i && (inflight_m == max_ld_lp);
            e_stall   = busy_read || too_many;
            e_fetch   = e_stall;
            e_issue   = hz_if.dec_v_i && !e_stall;
         end
      end
      check_eq("issue", hz_if.issue_v_o, e_issue);
      check_eq("dstall", hz_if.decode_stall_v_o, e_stall);
      check_eq("dflush", hz_if.decode_flush_v_o, e_flush);
      check_eq("fstall", hz_if.fetch_stall_v_o, e_fetch);
      check_eq("err", hz_if.err_o, e_err);

      if (rst) begin
         busy_m = '0; inflight_m = 0; br_out_m = 0; flush_left_m = 0; err_m = 0;
      end else begin
         if (hz_if.ld_done_v_i) begin
            if (inflight_m == 0) err_m = 1;
            busy_m[hz_if.ld_done_rd_i] = 1'b0;
         end
         if (e_issue && hz_if.dec_ld_v_i && hz_if.dec_rd_i != 5'd0)
            busy_m[hz_if.dec_rd_i] = 1'b1;
         if (e_issue && hz_if.dec_ld_v_i && !hz_if.ld_done_v_i)
            inflight_m++;
         else if (!(e_issue && hz_if.dec_ld_v_i) && hz_if.ld_done_v_i && inflight_m > 0)
            inflight_m--;
         if (flush_left_m > 0) begin
            if (hz_if.br_res_v_i) err_m = 1;
            flush_left_m--;
         end else if (br_out_m) begin
            if (hz_if.br_res_v_i) begin
               br_out_m = 0;
               if (hz_if.br_taken_i) flush_left_m = flush_lp;
            end
         end else begin
            if (hz_if.br_res_v_i) err_m = 1;
            if (e_issue && hz_if.dec_br_v_i) br_out_m = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0;
      n_total = 0;
      n_bad = 0;
      busy_m = '0; inflight_m = 0; br_out_m = 0; flush_left_m = 0; err_m = 0;
      clear_in();
      @(posedge clk);
      #1;

      // reset cycle, then idle cycle
      rst = 1'b1; step();
      rst = 1'b0; step();

      // load x5, dependent read stalls until completion, issues the cycle after
      hz_if.dec_v_i = 1; hz_if.dec_ld_v_i = 1; hz_if.dec_rd_i = 5'd5; step();
      clear_in();
      hz_if.dec_v_i = 1; hz_if.dec_rs1_v_i = 1; hz_if.dec_rs1_i = 5'd5;
      repeat (3) step();
      hz_if.ld_done_v_i = 1; hz_if.ld_done_rd_i = 5'd5; step();
      hz_if.ld_done_v_i = 0; step();

      // load x0 then read x0: never stalls
      clear_in();
      hz_if.dec_v_i = 1; hz_if.dec_ld_v_i = 1; hz_if.dec_rd_i = 5'd0; step();
      clear_in();
      hz_if.dec_v_i = 1; hz_if.dec_rs1_v_i = 1; hz_if.dec_rs2_v_i = 1; step(); step();
      clear_in();
      hz_if.ld_done_v_i = 1; step();

      // two loads in flight, third stalls; completion frees it next cycle
      clear_in();
      hz_if.dec_v_i = 1; hz_if.dec_ld_v_i = 1;
      hz_if.dec_rd_i = 5'd1; step();
      hz_if.dec_rd_i = 5'd2; step();
      hz_if.dec_rd_i = 5'd3; step();
      hz_if.ld_done_v_i = 1; hz_if.ld_done_rd_i = 5'd1; step();
      hz_if.ld_done_v_i = 0; step();
      clear_in();
      hz_if.ld_done_v_i = 1; hz_if.ld_done_rd_i = 5'd2; step();
      hz_if.ld_done_rd_i = 5'd3; step();

      // taken branch resolved three cycles later, then two flush cycles
      clear_in();
      hz_if.dec_v_i = 1; hz_if.dec_br_v_i = 1; step();
      hz_if.dec_br_v_i = 0; step(); step();
      hz_if.br_res_v_i = 1; hz_if.br_taken_i = 1; step();
      clear_in();
      hz_if.dec_v_i = 1; step(); step(); step();

      // not-taken branch: back to issuing right after resolve
      hz_if.dec_br_v_i = 1; step();
      hz_if.dec_br_v_i = 0; hz_if.br_res_v_i = 1; step();
      hz_if.br_res_v_i = 0; step();

      // protocol errors are sticky until reset
      clear_in();
      hz_if.ld_done_v_i = 1; step();
      hz_if.ld_done_v_i = 0; step(); step();
      rst = 1; step();
      rst = 0; step();
      hz_if.br_res_v_i = 1; step();
      hz_if.br_res_v_i = 0; step(); step();
      rst = 1; step();
      rst = 0; step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst                = ($urandom_range(0, 199) == 0);
         hz_if.dec_v_i      = ($urandom_range(0, 3) != 0);
         hz_if.dec_rs1_v_i  = $urandom_range(0, 1);
         hz_if.dec_rs1_i    = 5'($urandom_range(0, 7));
         hz_if.dec_rs2_v_i  = $urandom_range(0, 1);
         hz_if.dec_rs2_i    = 5'($urandom_range(0, 7));
         hz_if.dec_ld_v_i   = ($urandom_range(0, 2) == 0);
         hz_if.dec_rd_i     = 5'($urandom_range(0, 7));
         hz_if.dec_br_v_i   = ($urandom_range(0, 7) == 0);
         hz_if.ld_done_v_i  = ((inflight_m > 0) && ($urandom_range(0, 2) == 0)) ||
                              ($urandom_range(0, 299) == 0);
         hz_if.ld_done_rd_i = 5'($urandom_range(0, 7));
         hz_if.br_res_v_i   = (br_out_m && ($urandom_range(0, 2) == 0)) ||
                              ($urandom_range(0, 299) == 0);
         hz_if.br_taken_i   = $urandom_range(0, 1);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
